// File: rtl/gradient_pkg.sv
// -----------------------------------------------------------------------------
// gradient_pkg
// Shared types and constants for the dithered-gradient sequencer.
//   fade_state_t : fade FSM state encoding
//   LEVEL_W      : width of a ROM level / brightness value
//   LEVEL_MAX    : brightest level (full scale)
//   POS_W        : width of the raster position inputs
// -----------------------------------------------------------------------------
package gradient_pkg;

  localparam int LEVEL_W = 7;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 7'd127;
  localparam int POS_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FADE_IN  = 2'd1,
    ST_HOLD     = 2'd2,
    ST_FADE_OUT = 2'd3
  } fade_state_t;

endpackage

// File: rtl/gradient_seq_if.sv
// -----------------------------------------------------------------------------
// gradient_seq_if
// Address/data port of the shared dithered-gradient lookup ROM.
//   rom_y     : level address (7 bits)
//   rom_x     : dither-bit select (2 bits)
//   rom_pixel : combinational ROM data for the current rom_y/rom_x
// Modports:
//   master : the sequencer (drives the address, reads the data)
//   slave  : the ROM (reads the address, drives the data)
// -----------------------------------------------------------------------------
interface gradient_seq_if;
  import gradient_pkg::*;

  logic [LEVEL_W-1:0] rom_y;
  logic [1:0]         rom_x;
  logic               rom_pixel;

  modport master (output rom_y, output rom_x, input rom_pixel);
  modport slave  (input rom_y, input rom_x, output rom_pixel);
endinterface

// File: rtl/gradient_fade_fsm.sv
// -----------------------------------------------------------------------------
// gradient_fade_fsm
// Frame-synchronous brightness fade controller: IDLE -> FADE_IN -> HOLD ->
// FADE_OUT -> IDLE. Brightness only moves on frame_start cycles.
// Optional feature macro: GRADIENT_SEQ_LOOP_EN -- when defined, FADE_OUT
// reaching 0 goes straight back to FADE_IN so the sequence repeats forever.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   frame_start : one-cycle pulse at the start of each frame
//   start       : one-cycle request to begin a fade (ignored while busy)
//   busy        : high in any state other than IDLE
//   brightness  : current fade brightness b
// -----------------------------------------------------------------------------
module gradient_fade_fsm
  import gradient_pkg::*;
#(
  parameter int FADE_STEP   = 1,
  parameter int HOLD_FRAMES = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               start,
  output logic               busy,
  output logic [LEVEL_W-1:0] brightness
);

  localparam int HC_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HC_W-1:0]    HOLD_LAST = HC_W'(HOLD_FRAMES - 1);
  localparam logic [LEVEL_W:0]   STEP_W    = (LEVEL_W + 1)'(FADE_STEP);
  localparam logic [LEVEL_W-1:0] STEP_N    = LEVEL_W'(FADE_STEP);

  fade_state_t        r_state, w_state_next;
  logic [LEVEL_W-1:0] r_b, w_b_next;
  logic [HC_W-1:0]    r_hold_cnt, w_hold_cnt_next;

  logic [LEVEL_W:0]   w_sum;
  logic [LEVEL_W-1:0] w_up;
  logic [LEVEL_W-1:0] w_down;

  // Saturating step in both directions; one extra bit catches the upward carry.
  assign w_sum  = {1'b0, r_b} + STEP_W;
  assign w_up   = (w_sum > {1'b0, LEVEL_MAX}) ? LEVEL_MAX : w_sum[LEVEL_W-1:0];
  assign w_down = (r_b > STEP_N) ? (r_b - STEP_N) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_b        <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_b        <= w_b_next;
      r_hold_cnt <= w_hold_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_b_next        = r_b;
    w_hold_cnt_next = r_hold_cnt;
    case (r_state)
      ST_IDLE: begin
        w_b_next = '0;
        // A start coincident with frame_start only changes state; the
        // first brightness step waits for the following frame_start.
        if (start) w_state_next = ST_FADE_IN;
      end
      ST_FADE_IN: begin
        if (frame_start) begin
          w_b_next = w_up;
          if (w_up == LEVEL_MAX) begin
            w_state_next    = ST_HOLD;
            w_hold_cnt_next = '0;
          end
        end
      end
      ST_HOLD: begin
        if (frame_start) begin
          if (r_hold_cnt == HOLD_LAST) w_state_next = ST_FADE_OUT;
          else w_hold_cnt_next = r_hold_cnt + 1'b1;
        end
      end
      ST_FADE_OUT: begin
        if (frame_start) begin
          w_b_next = w_down;
          if (w_down == '0) begin
`ifdef GRADIENT_SEQ_LOOP_EN
            w_state_next = ST_FADE_IN;
`else
            w_state_next = ST_IDLE;
`endif
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign busy       = (r_state != ST_IDLE);
  assign brightness = r_b;

endmodule

// File: rtl/gradient_seq.sv
// -----------------------------------------------------------------------------
// gradient_seq
// Sequencer for the shared dithered-gradient ROM. Maps raster position plus
// the current fade brightness to a registered ROM address, and returns the
// ROM bit two cycles after the position was sampled, qualified by pix_valid.
// Optional feature macro: GRADIENT_SEQ_LOOP_EN (see gradient_fade_fsm).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   frame_start     : one-cycle pulse at the start of each frame
//   pix_valid       : active-display qualifier for hpos/vpos
//   hpos, vpos      : raster column / row
//   start           : one-cycle request to begin a fade sequence
//   rom             : ROM port (master side: rom_y, rom_x out; rom_pixel in)
//   pixel_out       : final pixel, 0 whenever pixel_valid_out is 0
//   pixel_valid_out : pix_valid delayed to align with pixel_out
//   busy            : fade FSM not idle
//   brightness      : current fade brightness b
// -----------------------------------------------------------------------------
module gradient_seq
  import gradient_pkg::*;
#(
  parameter int FADE_STEP   = 1,
  parameter int HOLD_FRAMES = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [POS_W-1:0]   hpos,
  input  logic [POS_W-1:0]   vpos,
  input  logic               start,
  gradient_seq_if.master     rom,
  output logic               pixel_out,
  output logic               pixel_valid_out,
  output logic               busy,
  output logic [LEVEL_W-1:0] brightness
);

  logic [LEVEL_W-1:0] w_b;
  logic [LEVEL_W-1:0] w_base;
  logic [LEVEL_W-1:0] w_d;
  logic [LEVEL_W-1:0] w_level;
  logic               w_unused_pos;

  logic [LEVEL_W-1:0] r_rom_y;
  logic [1:0]         r_rom_x;
  logic               r_valid1;
  logic               r_pixel_out;
  logic               r_pixel_valid;

  gradient_fade_fsm #(
    .FADE_STEP   (FADE_STEP),
    .HOLD_FRAMES (HOLD_FRAMES)
  ) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .start       (start),
    .busy        (busy),
    .brightness  (w_b)
  );

  // Four rows share one level; the darker the fade, the further the whole
  // gradient is shifted down, clamping at level 0 instead of wrapping.
  assign w_base  = vpos[8:2];
  assign w_d     = LEVEL_MAX - w_b;
  assign w_level = (w_base >= w_d) ? (w_base - w_d) : '0;

  // Position bits that do not take part in the lookup.
  assign w_unused_pos = ^{vpos[9], vpos[1], hpos[POS_W-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rom_y       <= '0;
      r_rom_x       <= '0;
      r_valid1      <= 1'b0;
      r_pixel_out   <= 1'b0;
      r_pixel_valid <= 1'b0;
    end else begin
      r_rom_y       <= w_level;
      r_rom_x       <= {vpos[0], hpos[0]};
      r_valid1      <= pix_valid;
      r_pixel_out   <= rom.rom_pixel & r_valid1;
      r_pixel_valid <= r_valid1;
    end
  end

  assign rom.rom_y       = r_rom_y;
  assign rom.rom_x       = r_rom_x;
  assign pixel_out       = r_pixel_out;
  assign pixel_valid_out = r_pixel_valid;
  assign brightness      = w_b;

endmodule

// File: tb/tb_gradient_seq.sv
// -----------------------------------------------------------------------------
// tb_gradient_seq
// Directed bench for gradient_seq with FADE_STEP=32, HOLD_FRAMES=2. The ROM is
// modelled here as rom_pixel = (rom_y > 32*rom_x), so level 0 is always 0.
// -----------------------------------------------------------------------------
module tb_gradient_seq;
  import gradient_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       pix_valid;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       start;
  logic       pixel_out;
  logic       pixel_valid_out;
  logic       busy;
  logic [6:0] brightness;

  int total = 0;
  int bad   = 0;

  gradient_seq_if rom_if ();

  assign rom_if.rom_pixel = (rom_if.rom_y > {rom_if.rom_x, 5'd0});

  gradient_seq #(
    .FADE_STEP   (32),
    .HOLD_FRAMES (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .frame_start     (frame_start),
    .pix_valid       (pix_valid),
    .hpos            (hpos),
    .vpos            (vpos),
    .start           (start),
    .rom             (rom_if.master),
    .pixel_out       (pixel_out),
    .pixel_valid_out (pixel_valid_out),
    .busy            (busy),
    .brightness      (brightness)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic chk_b(input string name, input logic [6:0] exp_b, input logic exp_busy);
    total++;
    if (brightness !== exp_b || busy !== exp_busy) begin
      bad++;
      $display("FAIL %s: brightness=%0d busy=%0b, required brightness=%0d busy=%0b",
               name, brightness, busy, exp_b, exp_busy);
    end else
      $display("ok   %s: brightness=%0d busy=%0b", name, brightness, busy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_start = 1'b0; start = 1'b0;
    pix_valid = 1'b1; hpos = 10'd0; vpos = 10'd479;
    tick();
    tick();
    total++;
    if (rom_if.rom_y !== 7'd0 || rom_if.rom_x !== 2'd0 || pixel_out !== 1'b0 ||
        pixel_valid_out !== 1'b0 || busy !== 1'b0 || brightness !== 7'd0) begin
      bad++;
      $display("FAIL reset: rom_y=%0d rom_x=%0d pix=%0b pv=%0b busy=%0b b=%0d, required all 0",
               rom_if.rom_y, rom_if.rom_x, pixel_out, pixel_valid_out, busy, brightness);
    end else
      $display("ok   reset: all outputs 0");
    rst = 1'b0;
    tick();
    tick();
    // vpos=479: base 119 < d 127 -> level 0; rom_x={1,0}=2; ROM(0,2)=0
    total++;
    if (rom_if.rom_y !== 7'd0 || rom_if.rom_x !== 2'd2 || pixel_valid_out !== 1'b1 ||
        pixel_out !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_lookup: rom_y=%0d rom_x=%0d pv=%0b pix=%0b busy=%0b, required 0 2 1 0 0",
               rom_if.rom_y, rom_if.rom_x, pixel_valid_out, pixel_out, busy);
    end else
      $display("ok   idle_lookup: rom_y=0 rom_x=2 pv=1 pix=0");
    frame_pulse();
    chk_b("idle_frame_no_step", 7'd0, 1'b0);
  endtask

  task automatic test_fade();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_b("start_fade_in", 7'd0, 1'b1);
    repeat (3) tick();
    chk_b("no_step_midframe", 7'd0, 1'b1);
    frame_pulse(); chk_b("fade_in_1", 7'd32, 1'b1);
    frame_pulse(); chk_b("fade_in_2", 7'd64, 1'b1);
    frame_pulse(); chk_b("fade_in_3", 7'd96, 1'b1);

    // d = 31 at b = 96
    vpos = 10'd100; hpos = 10'd0; tick();
    total++;
    if (rom_if.rom_y !== 7'd0) begin
      bad++;
      $display("FAIL arith_b96_v100: rom_y=%0d, required 0", rom_if.rom_y);
    end else $display("ok   arith_b96_v100: rom_y=0");
    vpos = 10'd480; tick();
    total++;
    if (rom_if.rom_y !== 7'd89) begin
      bad++;
      $display("FAIL arith_b96_v480: rom_y=%0d, required 89", rom_if.rom_y);
    end else $display("ok   arith_b96_v480: rom_y=89");

    frame_pulse(); chk_b("fade_in_sat", 7'd127, 1'b1);
    vpos = 10'd4; tick();
    total++;
    if (rom_if.rom_y !== 7'd1) begin
      bad++;
      $display("FAIL arith_b127_v4: rom_y=%0d, required 1", rom_if.rom_y);
    end else $display("ok   arith_b127_v4: rom_y=1");

    // Full-brightness pixel: vpos=479,hpos=1 -> level 119, x=3, ROM(119,3)=1
    vpos = 10'd479; hpos = 10'd1; pix_valid = 1'b1;
    tick(); tick();
    total++;
    if (pixel_out !== 1'b1 || pixel_valid_out !== 1'b1) begin
      bad++;
      $display("FAIL pixel_lit: pix=%0b pv=%0b, required 1 1", pixel_out, pixel_valid_out);
    end else $display("ok   pixel_lit: pix=1 pv=1");
    pix_valid = 1'b0;
    tick(); tick();
    total++;
    if (pixel_out !== 1'b0 || pixel_valid_out !== 1'b0) begin
      bad++;
      $display("FAIL pixel_masked: pix=%0b pv=%0b, required 0 0", pixel_out, pixel_valid_out);
    end else $display("ok   pixel_masked: pix=0 pv=0");

    // start during HOLD must not disturb the sequence
    start = 1'b1; tick(); start = 1'b0;
    chk_b("start_in_hold", 7'd127, 1'b1);
    frame_pulse(); chk_b("hold_1", 7'd127, 1'b1);
    frame_pulse(); chk_b("hold_2_to_fade_out", 7'd127, 1'b1);
    frame_pulse(); chk_b("fade_out_1", 7'd95, 1'b1);
    frame_pulse(); chk_b("fade_out_2", 7'd63, 1'b1);
    frame_pulse(); chk_b("fade_out_3", 7'd31, 1'b1);
    frame_pulse();
`ifdef GRADIENT_SEQ_LOOP_EN
    chk_b("fade_out_end_loop", 7'd0, 1'b1);
    frame_pulse(); chk_b("loop_fade_in_1", 7'd32, 1'b1);
`else
    chk_b("fade_out_end_idle", 7'd0, 1'b0);
    frame_pulse(); chk_b("idle_after_fade", 7'd0, 1'b0);
`endif
  endtask

  task automatic test_pipeline();
    int cyc;
    do_reset();
    pix_valid = 1'b0; hpos = 10'd0; vpos = 10'd0;
    cyc = 0;
    for (int i = 0; i < 14; i++) begin
      // Inputs for cycle i are applied here and sampled at the next edge.
      if (i == 10) begin
        pix_valid = 1'b1; hpos = 10'd1; vpos = 10'd3;
      end else begin
        pix_valid = 1'b0; hpos = 10'd0; vpos = 10'd0;
      end
      tick();
      cyc = i + 1;
      if (cyc == 11) begin
        total++;
        if (rom_if.rom_x !== 2'd3 || pixel_valid_out !== 1'b0) begin
          bad++;
          $display("FAIL pipe_c11: rom_x=%0d pv=%0b, required 3 0", rom_if.rom_x, pixel_valid_out);
        end else $display("ok   pipe_c11: rom_x=3 pv=0");
      end
      total++;
      if (pixel_valid_out !== (cyc == 12) || (pixel_valid_out === 1'b0 && pixel_out !== 1'b0)) begin
        bad++;
        $display("FAIL pipe_valid_c%0d: pv=%0b pix=%0b, required pv=%0b", cyc,
                 pixel_valid_out, pixel_out, (cyc == 12));
      end else $display("ok   pipe_valid_c%0d: pv=%0b pix=%0b", cyc, pixel_valid_out, pixel_out);
    end
  endtask

  task automatic test_events();
    do_reset();
    start = 1'b1; frame_start = 1'b1;
    tick();
    start = 1'b0; frame_start = 1'b0;
    chk_b("start_with_frame", 7'd0, 1'b1);
    frame_pulse(); chk_b("first_step_after", 7'd32, 1'b1);
    repeat (3) frame_pulse();           // 64, 96, 127 -> HOLD
    repeat (2) frame_pulse();           // HOLD -> FADE_OUT
    frame_pulse(); chk_b("fade_out_before_rst", 7'd95, 1'b1);
    pix_valid = 1'b1; vpos = 10'd479; hpos = 10'd1;
    tick();                             // fill the pipeline
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_b("rst_mid_fade_out", 7'd0, 1'b0);
    total++;
    if (pixel_valid_out !== 1'b0 || pixel_out !== 1'b0) begin
      bad++;
      $display("FAIL rst_pipe_clear: pv=%0b pix=%0b, required 0 0", pixel_valid_out, pixel_out);
    end else $display("ok   rst_pipe_clear: pv=0 pix=0");
    pix_valid = 1'b0;
    frame_pulse(); chk_b("idle_after_rst", 7'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; start = 1'b0;
    pix_valid = 1'b0; hpos = '0; vpos = '0;
    test_reset();
    test_fade();
    test_pipeline();
    test_events();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
